// File: rtl/weight_sram_banked_pkg.sv
// lenet_mem_pkg: geometry defaults and weight-region map for the LeNet weight store
package lenet_mem_pkg;
    localparam int LANE_W = 4;
    localparam int LANES  = 25;
    localparam int DW     = LANES * LANE_W;
    localparam int DEPTH  = 20000;
    localparam int AW     = 15;

    localparam int CONV1_W_BASE = 0;
    localparam int CONV1_B_ADDR = 20;
    localparam int CONV2_W_BASE = 21;
    localparam int CONV2_B_BASE = 1021;
    localparam int FC1_W_BASE   = 1100;
    localparam int SCORE_W_BASE = 17100;
    localparam int SCORE_W_END  = 17299;
endpackage

// File: rtl/weight_sram_banked_if.sv
// weight_sram_banked_if: weight-load / weight-fetch bus of the banked weight store
interface weight_sram_banked_if
    import lenet_mem_pkg::*;
#(
    parameter int N_LANES = LANES,
    parameter int WIDTH   = DW,
    parameter int ADDR_W  = AW
);
    logic               csb;
    logic               wsb;
    logic [N_LANES-1:0] wmask;
    logic [ADDR_W-1:0]  waddr;
    logic [WIDTH-1:0]   wdata;
    logic [ADDR_W-1:0]  raddr;
    logic [WIDTH-1:0]   rdata;
    logic               rvalid;
    logic               addr_err;

    modport master (output csb, wsb, wmask, waddr, wdata, raddr, input rdata, rvalid, addr_err);
    modport slave  (input csb, wsb, wmask, waddr, wdata, raddr, output rdata, rvalid, addr_err);
endinterface

// File: rtl/weight_sram_banked_rd_pipe.sv
// sram_rd_pipe: LAT-deep read-result shift register; the tail holds the last valid word
module sram_rd_pipe
    import lenet_mem_pkg::*;
#(
    parameter int W   = DW,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vld_i,
    input  logic [W-1:0] data_i,
    output logic         vld_o,
    output logic [W-1:0] data_o
);
    logic [LAT:1]  vld_q;
    logic [W-1:0]  dat_q [1:LAT];
    logic [LAT:0]  vin;
    logic [W-1:0]  din [0:LAT];

    // stage inputs: stage i is fed from stage i-1, stage 1 from the array read
    always_comb begin
        vin = {vld_q, vld_i};
        din[0] = data_i;
        for (int i = 1; i <= LAT; i++) din[i] = dat_q[i];
    end

    // valid shifts every cycle; data advances only behind a valid so idle slots keep the old word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 1; i <= LAT; i++) dat_q[i] <= '0;
        end else begin
            for (int i = 1; i <= LAT; i++) begin
                vld_q[i] <= vin[i-1];
                if (vin[i-1]) dat_q[i] <= din[i-1];
            end
        end
    end

    assign vld_o  = vld_q[LAT];
    assign data_o = dat_q[LAT];
endmodule

// File: rtl/weight_sram_banked.sv
// weight_sram_banked: lane-masked weight SRAM with configurable read latency and collision rule
module weight_sram_banked
    import lenet_mem_pkg::*;
#(
    parameter int LANE_W    = lenet_mem_pkg::LANE_W,
    parameter int LANES     = lenet_mem_pkg::LANES,
    parameter int DEPTH     = lenet_mem_pkg::DEPTH,
    parameter int AW        = lenet_mem_pkg::AW,
    parameter int RD_LAT    = 1,
    parameter int WR_BYPASS = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    weight_sram_banked_if.slave  bus
);
    localparam int DW = LANES * LANE_W;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] bit_mask, old_w, new_w, rd_word;
    logic          wr_ok, rd_ok, we, re, err_d, err_q;

    // address checks, lane-merged write word and the read word with the collision rule
    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < LANES; i++) bit_mask[i*LANE_W +: LANE_W] = {LANE_W{bus.wmask[i]}};
        wr_ok   = 32'(bus.waddr) < DEPTH;
        rd_ok   = 32'(bus.raddr) < DEPTH;
        we      = ~bus.csb & ~bus.wsb;
        re      = ~bus.csb;
        old_w   = wr_ok ? mem[bus.waddr] : '0;
        new_w   = (old_w & ~bit_mask) | (bus.wdata & bit_mask);
        rd_word = !rd_ok ? '0 :
                  (WR_BYPASS != 0 && we && wr_ok && bus.raddr == bus.waddr) ? new_w : mem[bus.raddr];
        err_d   = err_q | (re & ~rd_ok) | (we & ~wr_ok);
    end

    // array write; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (we && wr_ok) mem[bus.waddr] <= new_w;
    end

    // sticky out-of-range flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    sram_rd_pipe #(.W(DW), .LAT(RD_LAT)) u_rd_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_i  (re),
        .data_i (rd_word),
        .vld_o  (bus.rvalid),
        .data_o (bus.rdata)
    );

    assign bus.addr_err = err_q;

    task load_w(input logic [AW-1:0] index, input logic [DW-1:0] word);
        mem[index] <= word;
    endtask

    function automatic logic [DW-1:0] peek(input logic [AW-1:0] index);
        return mem[index];
    endfunction
endmodule

// File: tb/tb_weight_sram_banked.sv
// tb_weight_sram_banked: scoreboard bench over three latency / collision-rule configurations
module tb_weight_sram_banked;
    import lenet_mem_pkg::*;

    localparam int NDUT = 3;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    function automatic int lat_of(input int k);
        return k == 0 ? 1 : k == 1 ? 3 : 4;
    endfunction

    function automatic int byp_of(input int k);
        return k == 1 ? 1 : 0;
    endfunction

    function automatic logic [DW-1:0] fill(input logic [3:0] n);
        return {LANES{n}};
    endfunction

    function automatic logic [DW-1:0] bmask(input logic [LANES-1:0] m);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = {LANE_W{m[i]}};
        return r;
    endfunction

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             csb = 1'b1, wsb = 1'b1;
    logic [LANES-1:0] wmask = '0;
    logic [AW-1:0]    waddr = '0, raddr = '0;
    logic [DW-1:0]    wdata = '0;

    logic [NDUT-1:0]  rv_w, ae_w;
    logic [DW-1:0]    rd_w [NDUT];

    logic [DW-1:0]    model [DEPTH];
    logic [DW-1:0]    last [NDUT];
    logic             err_exp = 1'b0;
    int               ecnt = 0;
    exp_t             sb [NDUT][$];
    int               total = 0, bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_d
        weight_sram_banked_if #(.N_LANES(LANES), .WIDTH(DW), .ADDR_W(AW)) bus ();
        assign bus.csb   = csb;
        assign bus.wsb   = wsb;
        assign bus.wmask = wmask;
        assign bus.waddr = waddr;
        assign bus.wdata = wdata;
        assign bus.raddr = raddr;
        assign rv_w[g]   = bus.rvalid;
        assign rd_w[g]   = bus.rdata;
        assign ae_w[g]   = bus.addr_err;
        weight_sram_banked #(.RD_LAT(lat_of(g)), .WR_BYPASS(byp_of(g))) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // edge counter: index of the next active edge
    always @(posedge clk) ecnt <= ecnt + 1;

    // check results of the last edge, then record what the coming edge issues
    always @(negedge clk) begin
        logic          ev, wok, rok, hit;
        logic [DW-1:0] old_w, new_w, rd;
        for (int k = 0; k < NDUT; k++) begin
            if (!rst_n) begin
                sb[k].delete();
                last[k] = '0;
                check($sformatf("d%0d rst_rvalid", k), DW'(rv_w[k]), '0);
                check($sformatf("d%0d rst_rdata", k), rd_w[k], '0);
                check($sformatf("d%0d rst_addr_err", k), DW'(ae_w[k]), '0);
            end else begin
                ev = sb[k].size() != 0 && sb[k][0].due == ecnt - 1;
                check($sformatf("d%0d rvalid@%0d", k, ecnt - 1), DW'(rv_w[k]), DW'(ev));
                if (ev) begin
                    last[k] = sb[k][0].data;
                    void'(sb[k].pop_front());
                end
                check($sformatf("d%0d rdata@%0d", k, ecnt - 1), rd_w[k], last[k]);
                check($sformatf("d%0d addr_err@%0d", k, ecnt - 1), DW'(ae_w[k]), DW'(err_exp));
            end
        end
        if (!rst_n) err_exp = 1'b0;
        else if (!csb) begin
            wok   = int'(waddr) < DEPTH;
            rok   = int'(raddr) < DEPTH;
            old_w = wok ? model[waddr] : '0;
            new_w = (old_w & ~bmask(wmask)) | (wdata & bmask(wmask));
            hit   = !wsb && wok && raddr == waddr;
            for (int k = 0; k < NDUT; k++) begin
                rd = !rok ? '0 : (hit && byp_of(k) != 0) ? new_w : model[raddr];
                sb[k].push_back('{rd, ecnt + lat_of(k) - 1});
            end
            if (!wsb && wok) model[waddr] = new_w;
            if ((!wsb && !wok) || !rok) err_exp = 1'b1;
        end
    end

    task automatic pre(input int a, input logic [DW-1:0] w);
        g_d[0].u_dut.load_w(AW'(a), w);
        g_d[1].u_dut.load_w(AW'(a), w);
        g_d[2].u_dut.load_w(AW'(a), w);
        model[AW'(a)] = w;
    endtask

    task automatic dump(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) $display("w[%0d]=%b", i, g_d[0].u_dut.peek(AW'(i)));
    endtask

    task automatic op(input logic cs, input logic ws, input logic [LANES-1:0] wm,
                      input int wa, input logic [DW-1:0] wd, input int ra);
        @(posedge clk);
        #1;
        csb = cs; wsb = ws; wmask = wm; waddr = AW'(wa); wdata = wd; raddr = AW'(ra);
    endtask

    task automatic rd(input int a);
        op(1'b0, 1'b1, '0, 0, '0, a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b1, 1'b1, '0, 0, '0, 0);
    endtask

    initial begin
        logic [127:0] r;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(10);
        pre(CONV1_B_ADDR, fill(4'h3));
        pre(CONV2_W_BASE, '1);
        for (int i = 0; i < 10; i++) pre(FC1_W_BASE + i, fill(4'(i + 1)) ^ DW'(i * 97));
        pre(SCORE_W_BASE, fill(4'hA));
        pre(DEPTH - 1, fill(4'h6));
        op(1'b0, 1'b0, 25'h0000001, CONV2_W_BASE, '0, CONV1_B_ADDR);
        rd(CONV2_W_BASE);
        idle(6);
        check("masked_word", g_d[0].u_dut.peek(AW'(CONV2_W_BASE)), {{24{4'hF}}, 4'h0});
        for (int i = 0; i < 10; i++) rd(FC1_W_BASE + i);
        idle(6);
        op(1'b0, 1'b0, '1, SCORE_W_BASE, fill(4'h5), SCORE_W_BASE);
        rd(SCORE_W_BASE);
        idle(6);
        check("collide_word", g_d[1].u_dut.peek(AW'(SCORE_W_BASE)), fill(4'h5));
        for (int i = 0; i < 40; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            op(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), LANES'($urandom),
               FC1_W_BASE + int'($urandom_range(0, 9)), r[DW-1:0], FC1_W_BASE + int'($urandom_range(0, 9)));
        end
        idle(6);
        op(1'b0, 1'b0, '1, DEPTH, fill(4'h9), DEPTH - 1);
        rd(DEPTH + 1);
        idle(6);
        dump(DEPTH - 1, DEPTH - 1);
        check("oor_keep", g_d[0].u_dut.peek(AW'(DEPTH - 1)), fill(4'h6));
        rd(FC1_W_BASE);
        rd(FC1_W_BASE + 1);
        idle(1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(6);
        for (int i = 0; i < 4; i++) rd(FC1_W_BASE + i);
        idle(8);
        for (int k = 0; k < NDUT; k++) check($sformatf("d%0d drain", k), DW'(sb[k].size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
